// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RISC-V fetch stage holding the PC, fetching from variable-latency memory and presenting the instruction.
//  clk_i          rising-edge clock
//  rst_n_i        asynchronous active-low reset
//  imem_req_o     one-cycle fetch request, imem_addr_o = pc
//  imem_rvalid_i  read data valid, imem_rdata_i instruction word
//  instr_o        registered instruction, opcode_o = instr_o[6:2]
//  instr_valid_o  instruction valid, held until instr_ack_i
//  branch_i       branch request, taken only when zero_i is also set
//  zero_i         ALU zero flag
//  imm_i          halfword branch offset
//  pc_o           PC of instr_o
//  misalign_err_o pulse after an ack whose taken target had bit1 set
//  fetch_err_o    pulse when a fetch times out and is retried
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       instr_o,
    output logic [4:0]        opcode_o,
    output logic              instr_valid_o,
    input  logic              instr_ack_i,
    input  logic              branch_i,
    input  logic              zero_i,
    input  logic [ADDR_W-1:0] imm_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              misalign_err_o,
    output logic              fetch_err_o
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {FETCH, WAIT, VALID} state_e;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d, target;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d, ferr_q, ferr_d, merr_q, merr_d, taken;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            merr_q  <= merr_d;
        end
    end
    assign taken  = branch_i & zero_i;
    assign target = pc_q + (imm_i << 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        merr_d  = 1'b0;
        case (state_q)
            FETCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // a response on the final timeout cycle still counts
                if (imem_rvalid_i) begin
                    instr_d = imem_rdata_i;
                    valid_d = 1'b1;
                    state_d = VALID;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    ferr_d  = 1'b1;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            VALID: begin
                if (instr_ack_i) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                    pc_d    = taken ? {target[ADDR_W-1:2], 2'b00} : pc_q + ADDR_W'(4);
                    merr_d  = taken & target[1];
                end
            end
            default: state_d = FETCH;
        endcase
    end
    // gated by rst_n_i so the request drops immediately while reset is held
    assign imem_req_o     = (state_q == FETCH) & rst_n_i;
    assign imem_addr_o    = pc_q;
    assign pc_o           = pc_q;
    assign instr_o        = instr_q;
    assign opcode_o       = instr_q[6:2];
    assign instr_valid_o  = valid_q;
    assign fetch_err_o    = ferr_q;
    assign misalign_err_o = merr_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;
    logic        clk_i = 1'b0, rst_n_i = 1'b0;
    logic        imem_rvalid_i = 1'b0, instr_ack_i = 1'b0, branch_i = 1'b0, zero_i = 1'b0;
    logic [31:0] imem_rdata_i = '0, imm_i = '0;
    logic        imem_req_o, instr_valid_o, misalign_err_o, fetch_err_o;
    logic [31:0] imem_addr_o, instr_o, pc_o;
    logic [4:0]  opcode_o;
    int n_chk = 0, n_fail = 0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .instr_o(instr_o),
        .opcode_o(opcode_o), .instr_valid_o(instr_valid_o), .instr_ack_i(instr_ack_i),
        .branch_i(branch_i), .zero_i(zero_i), .imm_i(imm_i), .pc_o(pc_o),
        .misalign_err_o(misalign_err_o), .fetch_err_o(fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_resp(input int lat, input logic [31:0] data, input logic [31:0] exp_pc);
        logic [31:0] d;
        d = data;
        for (int i = 0; i < lat - 1; i++) tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        tick();
        imem_rvalid_i = 1'b0;
        check("valid", 32'(instr_valid_o), 32'd1);
        check("instr", instr_o, data);
        check("opcode", 32'(opcode_o), 32'(d[6:2]));
        check("pc", pc_o, exp_pc);
        check("fetch_err_clr", 32'(fetch_err_o), 32'd0);
    endtask

    task automatic do_fetch(input int lat, input logic [31:0] data, input logic [31:0] exp_addr);
        check("req", 32'(imem_req_o), 32'd1);
        check("addr", imem_addr_o, exp_addr);
        tick();
        check("req_drop", 32'(imem_req_o), 32'd0);
        wait_resp(lat, data, exp_addr);
    endtask

    task automatic ack(input logic br, input logic z, input logic [31:0] imm,
                       input logic [31:0] exp_addr, input logic exp_mis);
        instr_ack_i = 1'b1;
        branch_i    = br;
        zero_i      = z;
        imm_i       = imm;
        tick();
        instr_ack_i = 1'b0;
        branch_i    = 1'b0;
        zero_i      = 1'b0;
        imm_i       = 32'hA5A5_A5A5;
        check("ack_req", 32'(imem_req_o), 32'd1);
        check("ack_addr", imem_addr_o, exp_addr);
        check("ack_valid", 32'(instr_valid_o), 32'd0);
        check("misalign", 32'(misalign_err_o), 32'(exp_mis));
    endtask

    initial begin
        tick();
        tick();
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_instr", instr_o, 32'h13);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_ferr", 32'(fetch_err_o), 32'd0);
        check("rst_merr", 32'(misalign_err_o), 32'd0);
        rst_n_i = 1'b1;
        #1;
        check("rel_req", 32'(imem_req_o), 32'd1);
        check("rel_addr", imem_addr_o, 32'h0);
        do_fetch(1, 32'h0000_0033, 32'h0);
        ack(1'b0, 1'b1, 32'h0, 32'h4, 1'b0);
        do_fetch(3, 32'h0040_0063, 32'h4);
        ack(1'b0, 1'b0, 32'h0, 32'h8, 1'b0);
        do_fetch(1, 32'h0000_006F, 32'h8);
        ack(1'b0, 1'b0, 32'h0, 32'hC, 1'b0);
        do_fetch(3, 32'h0000_0003, 32'hC);
        ack(1'b0, 1'b0, 32'h0, 32'h10, 1'b0);
        do_fetch(1, 32'hFE00_0EE3, 32'h10);
        ack(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h8, 1'b0);
        do_fetch(1, 32'h0000_0023, 32'h8);
        ack(1'b1, 1'b1, 32'h2, 32'hC, 1'b0);
        do_fetch(1, 32'h0000_0037, 32'hC);
        ack(1'b0, 1'b0, 32'h0, 32'h10, 1'b0);
        do_fetch(1, 32'h0000_0017, 32'h10);
        ack(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h14, 1'b0);
        check("to_req", 32'(imem_req_o), 32'd1);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("to_pre_ferr", 32'(fetch_err_o), 32'd0);
        check("to_pre_req", 32'(imem_req_o), 32'd0);
        tick();
        check("to_ferr", 32'(fetch_err_o), 32'd1);
        do_fetch(1, 32'h0000_0073, 32'h14);
        ack(1'b0, 1'b0, 32'h0, 32'h18, 1'b0);
        do_fetch(16, 32'h0000_0013, 32'h18);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hFFFF_FFFF;
        tick();
        tick();
        imem_rvalid_i = 1'b0;
        check("hold_valid", 32'(instr_valid_o), 32'd1);
        check("hold_instr", instr_o, 32'h0000_0013);
        check("hold_req", 32'(imem_req_o), 32'd0);
        ack(1'b0, 1'b0, 32'h0, 32'h1C, 1'b0);
        tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        check("mid_req", 32'(imem_req_o), 32'd0);
        check("mid_pc", pc_o, 32'h0);
        check("mid_instr", instr_o, 32'h13);
        check("mid_valid", 32'(instr_valid_o), 32'd0);
        tick();
        rst_n_i       = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        check("mid_rel_req", 32'(imem_req_o), 32'd1);
        check("mid_rel_addr", imem_addr_o, 32'h0);
        tick();
        imem_rvalid_i = 1'b0;
        check("stale_instr", instr_o, 32'h13);
        check("stale_valid", 32'(instr_valid_o), 32'd0);
        wait_resp(2, 32'h0020_8063, 32'h0);
        ack(1'b1, 1'b1, 32'h1, 32'h0, 1'b1);
        tick();
        check("misalign_clr", 32'(misalign_err_o), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
